// File: rtl/rv_isa_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes and the immediate format code.
package rv_isa_pkg;

  localparam logic [6:0] OPC_R        = 7'b0110011;
  localparam logic [6:0] OPC_R_W      = 7'b0111011;
  localparam logic [6:0] OPC_I_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_I_ARTH   = 7'b0010011;
  localparam logic [6:0] OPC_I_ARTH_W = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_S        = 7'b0100011;
  localparam logic [6:0] OPC_B        = 7'b1100011;
  localparam logic [6:0] OPC_J        = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready instruction-in, immediate-out bus of the immediate generator.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction and format classification of one instruction word.
module imm_decode
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  localparam bit RV64 = (XLEN == 64);

  logic [31:0] imm32;
  logic [6:0]  opc;
  logic [2:0]  f3;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  // Every immediate is a 32-bit value sign-extended from bit 31; zero-extended fields keep bit 31 clear.
  always_comb begin
    imm32 = 32'd0;
    fmt   = FMT_ILL;
    if (inst[1:0] != 2'b11) begin
      imm32 = 32'd0;
      fmt   = FMT_ILL;
    end else begin
      case (opc)
        OPC_R: fmt = FMT_R;
        OPC_R_W: begin
          if (RV64) fmt = FMT_R;
          else      fmt = FMT_ILL;
        end
        OPC_I_LOAD, OPC_JALR: begin
          fmt   = FMT_I;
          imm32 = sext12(inst[31:20]);
        end
        OPC_I_ARTH: begin
          fmt = FMT_I;
          if (f3[1:0] == 2'b01) imm32 = RV64 ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
          else                  imm32 = sext12(inst[31:20]);
        end
        OPC_I_ARTH_W: begin
          if (RV64) begin
            fmt = FMT_I;
            if (f3[1:0] == 2'b01) imm32 = {27'd0, inst[24:20]};
            else                  imm32 = sext12(inst[31:20]);
          end else begin
            fmt = FMT_ILL;
          end
        end
        OPC_S: begin
          fmt   = FMT_S;
          imm32 = sext12({inst[31:25], inst[11:7]});
        end
        OPC_B: begin
          fmt   = FMT_B;
          imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt   = FMT_U;
          imm32 = {inst[31:12], 12'd0};
        end
        OPC_J: begin
          fmt   = FMT_J;
          imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          if (f3[2]) begin
            fmt   = FMT_Z;
            imm32 = {27'd0, inst[19:15]};
          end else begin
            fmt   = FMT_I;
            imm32 = sext12(inst[31:20]);
          end
        end
        default: begin
          fmt   = FMT_ILL;
          imm32 = 32'd0;
        end
      endcase
    end
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode ahead of an output register plus one skid entry,
// with a saturating count of accepted illegal words.
module imm_gen_pipe
  import rv_isa_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  imm_fmt_e         out_fmt_q,   out_fmt_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
  imm_fmt_e         skid_fmt_q,  skid_fmt_d;
  logic             in_ready_q,  in_ready_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic [ERR_W-1:0] err_base;
  logic             accept;
  logic             drain;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst (bus.in_inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  // Output/skid steering; in_ready is registered from the next skid state so out_ready never reaches it.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (!out_valid_q || drain) begin
      out_valid_d = accept;
      if (accept) begin
        out_imm_d = dec_imm;
        out_fmt_d = dec_fmt;
      end else begin
        out_imm_d = out_imm_q;
      end
    end else begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
      end else begin
        skid_valid_d = 1'b0;
      end
    end
    in_ready_d = !skid_valid_d;

    // Clear applies before the increment, so clear plus an illegal word leaves 1.
    err_base = err_clr ? {ERR_W{1'b0}} : err_cnt_q;
    if (accept && (dec_fmt == FMT_ILL) && (err_base != ERR_MAX)) err_cnt_d = err_base + ERR_W'(1);
    else                                                          err_cnt_d = err_base;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= {XLEN{1'b0}};
      out_fmt_q    <= FMT_R;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_fmt_q   <= FMT_R;
      in_ready_q   <= 1'b1;
      err_cnt_q    <= {ERR_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      in_ready_q   <= in_ready_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = (out_fmt_q == FMT_ILL);
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: one XLEN=32 and one XLEN=64 instance share a stimulus stream.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    bit          lat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, err_clr, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [7:0]  err32, err64;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_inst   = in_inst;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_inst   = in_inst;
  assign bus64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .ERR_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32), .err_clr(err_clr), .err_cnt(err32));
  imm_gen_pipe #(.XLEN(64), .ERR_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64), .err_clr(err_clr), .err_cnt(err64));

  logic        o_valid [2];
  logic        i_ready [2];
  logic        o_ill   [2];
  logic [63:0] o_imm   [2];
  logic [2:0]  o_fmt   [2];
  logic [7:0]  o_err   [2];

  assign o_valid[0] = bus32.out_valid;   assign o_valid[1] = bus64.out_valid;
  assign i_ready[0] = bus32.in_ready;    assign i_ready[1] = bus64.in_ready;
  assign o_ill[0]   = bus32.out_illegal; assign o_ill[1]   = bus64.out_illegal;
  assign o_imm[0]   = {32'd0, bus32.out_imm};
  assign o_imm[1]   = bus64.out_imm;
  assign o_fmt[0]   = bus32.out_fmt;     assign o_fmt[1]   = bus64.out_fmt;
  assign o_err[0]   = err32;             assign o_err[1]   = err64;

  exp_t        sbq [2][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_exp [2];
  bit          mon_en = 1'b0;
  bit          cur_dir = 1'b0;
  bit          cur_lat = 1'b0;
  logic [63:0] cur_imm [2];
  logic [2:0]  cur_fmt [2];
  bit          held [2];
  logic [63:0] h_imm [2];
  logic [2:0]  h_fmt [2];
  bit          rst_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference decode: field values taken as signed numbers and scaled, then truncated for RV32.
  function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    longint     v;
    logic [6:0] op;
    logic [2:0] f3;
    op  = w[6:0];
    f3  = w[14:12];
    v   = 0;
    fmt = 3'd7;
    if (w[1:0] == 2'b11) begin
      case (op)
        7'h33: fmt = 3'd0;
        7'h3B: if (x64) fmt = 3'd0;
        7'h03, 7'h67: begin fmt = 3'd1; v = $signed(w[31:20]); end
        7'h13, 7'h1B: begin
          if (op == 7'h13 || x64) begin
            fmt = 3'd1;
            if (f3 == 3'd1 || f3 == 3'd5) v = (op == 7'h1B || !x64) ? {59'd0, w[24:20]} : {58'd0, w[25:20]};
            else                          v = $signed(w[31:20]);
          end
        end
        7'h23: begin fmt = 3'd2; v = $signed({w[31:25], w[11:7]}); end
        7'h63: begin fmt = 3'd3; v = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2; end
        7'h37, 7'h17: begin fmt = 3'd4; v = $signed(w[31:12]) * 4096; end
        7'h6F: begin fmt = 3'd5; v = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2; end
        7'h73: begin
          if (f3[2]) begin fmt = 3'd6; v = {59'd0, w[19:15]}; end
          else       begin fmt = 3'd1; v = $signed(w[31:20]); end
        end
        default: fmt = 3'd7;
      endcase
    end
    imm = x64 ? v : {32'd0, v[31:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h3B, 7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: checks outputs and counter, then books what the coming edge will accept.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        chk($sformatf("err_cnt[x%0d]", d ? 64 : 32), {56'd0, o_err[d]}, 64'(err_exp[d]));
        if (held[d] && rst_prev) begin
          chk($sformatf("hold_valid[x%0d]", d ? 64 : 32), {63'd0, o_valid[d]}, 64'd1);
          chk($sformatf("hold_imm[x%0d]", d ? 64 : 32), o_imm[d], h_imm[d]);
          chk($sformatf("hold_fmt[x%0d]", d ? 64 : 32), {61'd0, o_fmt[d]}, {61'd0, h_fmt[d]});
        end
        if (rst_n && o_valid[d]) begin
          if (sbq[d].size() == 0) begin
            checks++; errors++;
            $display("FAIL stale_output[x%0d]: got imm %0h with no word outstanding", d ? 64 : 32, o_imm[d]);
          end else if (out_ready) begin
            e = sbq[d].pop_front();
            chk($sformatf("imm[x%0d]", d ? 64 : 32), o_imm[d], e.imm);
            chk($sformatf("fmt[x%0d]", d ? 64 : 32), {61'd0, o_fmt[d]}, {61'd0, e.fmt});
            chk($sformatf("illegal[x%0d]", d ? 64 : 32), {63'd0, o_ill[d]}, {63'd0, (e.fmt == 3'd7)});
            if (e.lat) chk($sformatf("latency[x%0d]", d ? 64 : 32), 64'(cyc), 64'(e.cyc + 1));
          end
        end
        held[d]  = rst_n && o_valid[d] && !out_ready;
        h_imm[d] = o_imm[d];
        h_fmt[d] = o_fmt[d];
        if (!rst_n) begin
          sbq[d].delete();
          err_exp[d] = 0;
        end else begin
          if (err_clr) err_exp[d] = 0;
          if (in_valid && i_ready[d]) begin
            if (cur_dir) begin e.imm = cur_imm[d]; e.fmt = cur_fmt[d]; end
            else         ref_dec(in_inst, d == 1, e.imm, e.fmt);
            e.lat = cur_lat;
            e.cyc = cyc;
            sbq[d].push_back(e);
            if (e.fmt == 3'd7 && err_exp[d] < 255) err_exp[d]++;
          end
        end
      end
      rst_prev = rst_n;
    end
  end

  task automatic send(input logic [31:0] w, input bit dir, input logic [63:0] i32, input logic [2:0] f32,
                      input logic [63:0] i64, input logic [2:0] f64, input bit lat, input bit rnd);
    bit ok;
    int n;
    cur_dir = dir; cur_lat = lat;
    cur_imm[0] = i32; cur_fmt[0] = f32; cur_imm[1] = i64; cur_fmt[1] = f64;
    in_inst = w; in_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = i_ready[0] && i_ready[1];
      n++;
      if (!ok) begin
        @(posedge clk); #1;
        if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cur_dir = 1'b0; cur_lat = 1'b0;
  endtask

  task automatic sendd(input logic [31:0] w, input logic [63:0] i32, input logic [2:0] f32,
                       input logic [63:0] i64, input logic [2:0] f64, input bit lat);
    send(w, 1'b1, i32, f32, i64, f64, lat, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid32", {63'd0, o_valid[0]}, 64'd0);
    chk("rst_out_valid64", {63'd0, o_valid[1]}, 64'd0);
    chk("rst_out_imm32", o_imm[0], 64'd0);
    chk("rst_out_imm64", o_imm[1], 64'd0);
    chk("rst_out_fmt32", {61'd0, o_fmt[0]}, 64'd0);
    chk("rst_err_cnt32", {56'd0, o_err[0]}, 64'd0);
    chk("rst_in_ready32", {63'd0, i_ready[0]}, 64'd1);
    chk("rst_in_ready64", {63'd0, i_ready[1]}, 64'd1);
    mon_en = 1'b1;

    // Back-to-back stream with latency tracking.
    out_ready = 1'b1;
    sendd(32'hFFF00093, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1);
    sendd(32'hFE112E23, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b1);
    sendd(32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b1);
    sendd(32'h800002B7, 64'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    sendd(32'h03F09093, 64'h0000001F, 3'd1, 64'h000000000000003F, 3'd1, 1'b0);
    sendd(32'h0FFFD073, 64'h0000001F, 3'd6, 64'h000000000000001F, 3'd6, 1'b0);
    sendd(32'h00000010, 64'h0, 3'd7, 64'h0, 3'd7, 1'b0);
    idle(2);
    chk("err_after_ill32", {56'd0, o_err[0]}, 64'd1);
    chk("err_after_ill64", {56'd0, o_err[1]}, 64'd1);

    // Back-pressure: two words fill output and skid, the third waits.
    out_ready = 1'b0;
    send(32'hFFF00093, 1'b0, 64'd0, 3'd0, 64'd0, 3'd0, 1'b0, 1'b0);
    send(32'h0FFFD073, 1'b0, 64'd0, 3'd0, 64'd0, 3'd0, 1'b0, 1'b0);
    chk("bp_in_ready32", {63'd0, i_ready[0]}, 64'd0);
    chk("bp_in_ready64", {63'd0, i_ready[1]}, 64'd0);
    fork
      send(32'h800002B7, 1'b0, 64'd0, 3'd0, 64'd0, 3'd0, 1'b0, 1'b0);
      begin
        idle(4);
        chk("bp_accepted32", 64'(sbq[0].size()), 64'd2);
        chk("bp_in_ready_held", {63'd0, i_ready[0]}, 64'd0);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", 64'(sbq[0].size() + sbq[1].size()), 64'd0);

    // Saturation then clear-with-increment.
    for (int i = 0; i < 260; i++) sendd(32'h00000010, 64'h0, 3'd7, 64'h0, 3'd7, 1'b0);
    chk("err_sat32", {56'd0, o_err[0]}, 64'd255);
    chk("err_sat64", {56'd0, o_err[1]}, 64'd255);
    err_clr = 1'b1;
    sendd(32'h00000010, 64'h0, 3'd7, 64'h0, 3'd7, 1'b0);
    err_clr = 1'b0;
    chk("err_clr_inc32", {56'd0, o_err[0]}, 64'd1);
    chk("err_clr_inc64", {56'd0, o_err[1]}, 64'd1);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      send(rand_word(), 1'b0, 64'd0, 3'd0, 64'd0, 3'd0, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    idle(5);
    chk("rand_drained32", 64'(sbq[0].size()), 64'd0);
    chk("rand_drained64", 64'(sbq[1].size()), 64'd0);

    // Reset with output and skid both occupied.
    out_ready = 1'b0;
    sendd(32'h00000010, 64'h0, 3'd7, 64'h0, 3'd7, 1'b0);
    sendd(32'h00000093, 64'h0, 3'd1, 64'h0, 3'd1, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h00000010;
    idle(1);
    chk("mid_rst_out_valid32", {63'd0, o_valid[0]}, 64'd0);
    chk("mid_rst_out_valid64", {63'd0, o_valid[1]}, 64'd0);
    chk("mid_rst_err32", {56'd0, o_err[0]}, 64'd0);
    chk("mid_rst_err64", {56'd0, o_err[1]}, 64'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk("post_rst_in_ready32", {63'd0, i_ready[0]}, 64'd1);
    chk("post_rst_in_ready64", {63'd0, i_ready[1]}, 64'd1);
    idle(10);
    chk("post_rst_quiet", {63'd0, o_valid[0] | o_valid[1]}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
